sprite_plotter: RTL and testbench

//  Rasterises one rectangular sprite (player, alien or bullet) into single-pixel plot

---
 rtl/sprite_plotter_if.sv | 26 ++
 rtl/sprite_plotter.sv | 138 +++++++++++++
 tb/tb_sprite_plotter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_plotter_if.sv
// Request/pixel bus between the draw/erase controller, the sprite plotter and the
// framebuffer writer. The plotter sits on the slave modport.
interface sprite_plotter_if;
  logic       start;
  logic       erase;
  logic [8:0] org_x;
  logic [7:0] org_y;
  logic [2:0] colour;
  logic       plot_ready;
  logic       busy;
  logic       finish;
  logic       plot;
  logic [8:0] plot_x;
  logic [7:0] plot_y;
  logic [2:0] plot_colour;

  modport master (
    output start, erase, org_x, org_y, colour, plot_ready,
    input  busy, finish, plot, plot_x, plot_y, plot_colour
  );

  modport slave (
    input  start, erase, org_x, org_y, colour, plot_ready,
    output busy, finish, plot, plot_x, plot_y, plot_colour
  );
endinterface

// File: rtl/sprite_plotter.sv
// Rasterises a WxH sprite into row-major single-pixel plot writes with screen clipping.
// Define SPRITE_MASK_EN to add a per-pixel MASK parameter (bit row*W+col, 0 = skip).
module sprite_plotter #(
  parameter int        W         = 8,
  parameter int        H         = 4,
  parameter int        SCREEN_W  = 320,
  parameter int        SCREEN_H  = 240,
  parameter logic [2:0] BG_COLOUR = 3'b000
`ifdef SPRITE_MASK_EN
  ,
  parameter logic [W*H-1:0] MASK = {(W*H){1'b1}}
`endif
) (
  input  logic              clk,
  input  logic              reset,
  sprite_plotter_if.slave   bus,
  output logic [1:0]        dbg_state
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [8:0]     org_x_q, org_x_d;
  logic [7:0]     org_y_q, org_y_d;
  logic [2:0]     colour_q, colour_d;
  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;

  logic [9:0]     pix_x;
  logic [8:0]     pix_y;
  logic           in_screen;
  logic           mask_on;
  logic           visible;
  logic           last_col;
  logic           last_row;

  // Wide sums so a sprite hanging off the right/bottom edge is clipped, never wrapped.
  assign pix_x     = 10'(org_x_q) + 10'(col_q);
  assign pix_y     = 9'(org_y_q) + 9'(row_q);
  assign in_screen = (pix_x < 10'(SCREEN_W)) && (pix_y < 9'(SCREEN_H));
  assign last_col  = (col_q == CW'(W - 1));
  assign last_row  = (row_q == RW'(H - 1));

`ifdef SPRITE_MASK_EN
  localparam int IW = (W * H > 1) ? $clog2(W * H) : 1;
  logic [IW-1:0] mask_idx;
  assign mask_idx = IW'(row_q) * IW'(W) + IW'(col_q);
  assign mask_on  = MASK[mask_idx];
`else
  assign mask_on  = 1'b1;
`endif

  assign visible   = in_screen && mask_on;
  assign dbg_state = state_q;

  // Handshake: a visible pixel is consumed only in a cycle with plot=1 and plot_ready=1;
  // hidden (clipped/masked) pixels are consumed unconditionally, one per cycle.
  always_comb begin
    state_d         = state_q;
    org_x_d         = org_x_q;
    org_y_d         = org_y_q;
    colour_d        = colour_q;
    col_d           = col_q;
    row_d           = row_q;
    bus.busy        = 1'b0;
    bus.finish      = 1'b0;
    bus.plot        = 1'b0;
    bus.plot_x      = '0;
    bus.plot_y      = '0;
    bus.plot_colour = '0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          org_x_d  = bus.org_x;
          org_y_d  = bus.org_y;
          colour_d = bus.erase ? BG_COLOUR : bus.colour;
          col_d    = '0;
          row_d    = '0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        bus.busy        = 1'b1;
        bus.plot        = visible;
        bus.plot_x      = pix_x[8:0];
        bus.plot_y      = pix_y[7:0];
        bus.plot_colour = colour_q;
        if (!visible || bus.plot_ready) begin
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              state_d = DONE;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      DONE: begin
        bus.busy   = 1'b1;
        bus.finish = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      org_x_q  <= '0;
      org_y_q  <= '0;
      colour_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
    end else begin
      state_q  <= state_d;
      org_x_q  <= org_x_d;
      org_y_q  <= org_y_d;
      colour_q <= colour_d;
      col_q    <= col_d;
      row_q    <= row_d;
    end
  end

endmodule

// File: tb/tb_sprite_plotter.sv
// Directed, table-driven bench for sprite_plotter: per-vector plot count, finish cycle,
// first pixel and a pixel-by-pixel expected queue, plus reset/abort sequences.
module tb_sprite_plotter;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  sprite_plotter_if bus ();

`ifdef SPRITE_MASK_EN
  localparam logic [31:0] TB_MASK = 32'h0000_00FF;
  sprite_plotter #(.MASK(32'h0000_00FF)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );
`else
  localparam logic [31:0] TB_MASK = 32'hFFFF_FFFF;
  sprite_plotter dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );
`endif

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [8:0] ox;
    logic [7:0] oy;
    logic [2:0] col;
    logic       er;
    int         stall_from;
    int         stall_len;
    int         pulse_cyc;
    int         exp_plots;
    int         exp_plots_mask;
    int         exp_fin;
    logic [8:0] fx;
    logic [7:0] fy;
    logic [2:0] exp_col;
  } vec_t;

  logic [19:0] exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  vec_t        vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_count(input vec_t v);
`ifdef SPRITE_MASK_EN
    return v.exp_plots_mask;
`else
    return v.exp_plots;
`endif
  endfunction

  task automatic build_expected(input vec_t v);
    int         x;
    int         y;
    logic [2:0] ecol;
    exp_q.delete();
    ecol = v.er ? 3'b000 : v.col;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        x = int'(v.ox) + c;
        y = int'(v.oy) + r;
        if (x < 320 && y < 240 && TB_MASK[r*8+c])
          exp_q.push_back({9'(x), 8'(y), ecol});
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic idle_inputs();
    bus.start      = 1'b0;
    bus.erase      = 1'b0;
    bus.org_x      = '0;
    bus.org_y      = '0;
    bus.colour     = '0;
    bus.plot_ready = 1'b1;
  endtask

  task automatic issue_start(input logic [8:0] ox, input logic [7:0] oy,
                             input logic [2:0] col, input logic er);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.org_x  = ox;
    bus.org_y  = oy;
    bus.colour = col;
    bus.erase  = er;
    @(posedge clk);
    #1;
    // Scramble request inputs: the sprite in flight must not notice.
    bus.start  = 1'b0;
    bus.org_x  = 9'($urandom_range(0, 511));
    bus.org_y  = 8'($urandom_range(0, 255));
    bus.colour = 3'($urandom_range(0, 7));
    bus.erase  = 1'($urandom_range(0, 1));
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          plots;
    int          fin_cyc;
    logic        in_stall;
    logic [19:0] got;
    logic [19:0] want;
    build_expected(v);
    issue_start(v.ox, v.oy, v.col, v.er);
    plots   = 0;
    fin_cyc = 0;
    for (int cyc = 1; cyc <= 60 && fin_cyc == 0; cyc++) begin
      in_stall = (v.stall_len > 0) && (cyc >= v.stall_from) && (cyc < v.stall_from + v.stall_len);
      bus.plot_ready = !in_stall;
      bus.start      = (v.pulse_cyc == cyc);
      if (v.pulse_cyc == cyc) begin
        bus.org_x  = 9'd100;
        bus.org_y  = 8'd100;
        bus.colour = 3'b111;
      end
      @(negedge clk);
      if (bus.finish) fin_cyc = cyc;
      if (in_stall && cyc > v.stall_from) begin
        check($sformatf("v%0d held_pixel c%0d", idx, cyc),
              32'({bus.plot, bus.plot_x, bus.plot_y}),
              32'({1'b1, v.ox + 9'd3, v.oy}));
      end
      if (bus.plot && bus.plot_ready) begin
        got = {bus.plot_x, bus.plot_y, bus.plot_colour};
        if (plots == 0) begin
          check($sformatf("v%0d first_pixel", idx), 32'(got), 32'({v.fx, v.fy, v.exp_col}));
        end
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hFFFFF;
        check($sformatf("v%0d pixel%0d", idx, plots), 32'(got), 32'(want));
        plots++;
      end
      @(posedge clk);
      #1;
    end
    bus.start      = 1'b0;
    bus.plot_ready = 1'b1;
    check($sformatf("v%0d finish_cycle", idx), 32'(fin_cyc), 32'(v.exp_fin));
    check($sformatf("v%0d plot_count", idx), 32'(plots), 32'(exp_count(v)));
    check($sformatf("v%0d leftover_expected", idx), 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check($sformatf("v%0d idle_after_finish", idx),
          32'({bus.busy, bus.plot, bus.finish, dbg_state}), 32'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    int saw_activity;
    //           ox   oy  col    er stl len pul  n  nm fin  fx   fy  ecol
    vecs[0] = '{9'd10,  8'd20,  3'b010, 1'b0, 0, 0, 0,  32, 8, 33, 9'd10,  8'd20,  3'b010};
    vecs[1] = '{9'd10,  8'd20,  3'b111, 1'b1, 0, 0, 0,  32, 8, 33, 9'd10,  8'd20,  3'b000};
    vecs[2] = '{9'd316, 8'd238, 3'b101, 1'b0, 0, 0, 0,  8,  4, 33, 9'd316, 8'd238, 3'b101};
    vecs[3] = '{9'd10,  8'd20,  3'b011, 1'b0, 4, 5, 0,  32, 8, 38, 9'd10,  8'd20,  3'b011};
    vecs[4] = '{9'd10,  8'd20,  3'b100, 1'b0, 0, 0, 10, 32, 8, 33, 9'd10,  8'd20,  3'b100};
    vecs[5] = '{9'd0,   8'd0,   3'b001, 1'b0, 0, 0, 0,  32, 8, 33, 9'd0,   8'd0,   3'b001};
    vecs[6] = '{9'd312, 8'd232, 3'b110, 1'b0, 0, 0, 0,  32, 8, 33, 9'd312, 8'd232, 3'b110};
    vecs[7] = '{9'd313, 8'd236, 3'b111, 1'b0, 0, 0, 0,  28, 7, 33, 9'd313, 8'd236, 3'b111};
    vecs[8] = '{9'd511, 8'd255, 3'b011, 1'b0, 0, 0, 0,  0,  0, 33, 9'd0,   8'd0,   3'b000};

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_outputs",
          32'({bus.busy, bus.finish, bus.plot, bus.plot_x, bus.plot_y, bus.plot_colour, dbg_state}),
          32'd0);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Reset asserted during cycle 15 of a sprite: abort, no finish afterwards.
    issue_start(9'd10, 8'd20, 3'b010, 1'b0);
    for (int cyc = 1; cyc < 15; cyc++) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(negedge clk);
    check("busy_before_abort", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_outputs", 32'({bus.busy, bus.plot, bus.finish, dbg_state}), 32'd0);
    saw_activity = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (bus.finish || bus.plot || bus.busy) saw_activity++;
    end
    check("no_finish_after_abort", 32'(saw_activity), 32'd0);

    // start and reset in the same cycle: reset wins.
    @(negedge clk);
    bus.start = 1'b1;
    bus.org_x = 9'd10;
    bus.org_y = 8'd20;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    check("start_with_reset_ignored", 32'({bus.busy, dbg_state}), 32'd0);

    // Recovery after the abort sequences.
    run_vec(9, vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
